// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet receive frame sequencer.
// Frame-level FSM states, drop reason codes and framing byte values.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PREAMBLE    = 3'd1,
        ST_HEADER      = 3'd2,
        ST_PAYLOAD     = 3'd3,
        ST_DROP        = 3'd4,
        ST_DROP_SILENT = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        RSN_NONE     = 3'd0,
        RSN_PREAMBLE = 3'd1,
        RSN_ADDR     = 3'd2,
        RSN_RUNT     = 3'd3,
        RSN_LONG     = 3'd4
    } drop_rsn_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          HDR_LEN       = 14;
    localparam int          FCS_LEN       = 4;
    localparam int          PREAMBLE_MAX  = 7;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

    // Destination accepted if promiscuous, addressed to us, or broadcast.
    function automatic logic addr_accept(input logic [47:0] dst,
                                         input logic [47:0] station,
                                         input logic        promisc);
        return promisc | (dst == station) | (dst == BCAST_MAC);
    endfunction

endpackage

// File: rtl/eth_fcs_strip.sv
// Delay line that withholds the trailing FCS bytes of a payload stream.
// A byte leaves only once DEPTH newer bytes exist, or on an explicit end-of-frame emit.
module eth_fcs_strip
    import eth_pkg::*;
#(
    parameter int DEPTH  = FCS_LEN + 1,
    parameter int FILL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [7:0]        din,
    input  logic              flush,
    input  logic              emit_last,
    output logic [7:0]        out_data,
    output logic              out_valid,
    output logic [FILL_W-1:0] fill
);

    logic [7:0]        line_r [DEPTH];
    logic [FILL_W-1:0] fill_r;
    logic              full_s;
    logic [7:0]        oldest_s;

    // Oldest occupied slot sits at index fill-1 of the shift line.
    always_comb begin
        oldest_s = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if (fill_r == FILL_W'(i + 1)) begin
                oldest_s = line_r[i];
            end else begin
                oldest_s = oldest_s;
            end
        end
    end

    assign full_s    = (fill_r == FILL_W'(DEPTH));
    assign out_data  = oldest_s;
    assign out_valid = (push && full_s) || (emit_last && (fill_r != {FILL_W{1'b0}}));
    assign fill      = fill_r;

    // Shift line and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_r <= {FILL_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                line_r[i] <= 8'h00;
            end
        end else if (flush || emit_last) begin
            fill_r <= {FILL_W{1'b0}};
        end else if (push) begin
            line_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                line_r[i] <= line_r[i-1];
            end
            if (!full_s) begin
                fill_r <= fill_r + FILL_W'(1);
            end
        end
    end

endmodule

// File: rtl/eth_rx_frame_ctrl.sv
// Receive frame sequencer: preamble/SFD lock, header parse, address filter,
// length policing and FCS-stripped payload forwarding with per-frame status.
module eth_rx_frame_ctrl
    import eth_pkg::*;
#(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518,
    parameter int CNT_W     = 11
) (
    input  logic             rxClkIn,
    input  logic             rstNIn,
    input  logic             enIn,
    input  logic             promiscIn,
    input  logic [47:0]      macAddrIn,
    input  logic [7:0]       rxDataIn,
    input  logic             rxDataValidIn,
    input  logic             rxDataLastIn,
    output logic [7:0]       payloadDataOut,
    output logic             payloadValidOut,
    output logic             payloadFirstOut,
    output logic             payloadLastOut,
    output logic [47:0]      srcMacOut,
    output logic [15:0]      etherTypeOut,
    output logic             frameGoodOut,
    output logic             frameDropOut,
    output logic [2:0]       dropReasonOut,
    output logic [CNT_W-1:0] frameLenOut
);

    localparam int FILL_W = $clog2(FCS_LEN + 2);

    state_t           state_r, state_s;
    drop_rsn_t        reason_r, reason_s, drop_code_s;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       pre_cnt_r;
    logic [3:0]       hdr_idx_r;
    logic [39:0]      dst_r;
    logic [47:0]      mac_r;
    logic             promisc_r, first_pend_r;
    logic byte_s, push_s, flush_s, emit_last_s, good_s, drop_s;
    logic sfd_s, cfg_s, to_payload_s, too_long_s, min_ok_s, addr_ok_s;
    logic [7:0]        strip_data_s;
    logic              strip_valid_s;
    logic [FILL_W-1:0] strip_fill_s;
    logic [7:0]        pay_data_r;
    logic              pay_valid_r, pay_first_r, pay_last_r, good_r, drop_r;
    logic [47:0]       src_mac_r;
    logic [15:0]       ether_type_r;
    logic [2:0]        reason_out_r;
    logic [CNT_W-1:0]  len_out_r;

    // A byte coinciding with the end-of-frame strobe is discarded.
    assign byte_s     = rxDataValidIn && !rxDataLastIn;
    assign too_long_s = (cnt_r >= CNT_W'(MAX_FRAME));
    assign min_ok_s   = (cnt_r >= CNT_W'(MIN_FRAME));
    assign addr_ok_s  = addr_accept({dst_r, rxDataIn}, mac_r, promisc_r);

    eth_fcs_strip #(.DEPTH(FCS_LEN + 1), .FILL_W(FILL_W)) u_strip (
        .clk       (rxClkIn),
        .rst_n     (rstNIn),
        .push      (push_s),
        .din       (rxDataIn),
        .flush     (flush_s),
        .emit_last (emit_last_s),
        .out_data  (strip_data_s),
        .out_valid (strip_valid_s),
        .fill      (strip_fill_s)
    );

    // Next-state and per-cycle control decode.
    always_comb begin
        state_s = state_r;  reason_s = reason_r;  drop_code_s = reason_r;
        push_s = 1'b0;  flush_s = 1'b0;  emit_last_s = 1'b0;  good_s = 1'b0;
        drop_s = 1'b0;  sfd_s = 1'b0;  cfg_s = 1'b0;  to_payload_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (byte_s && !enIn) begin
                    state_s = ST_DROP_SILENT;
                end else if (byte_s && (rxDataIn == PREAMBLE_BYTE)) begin
                    state_s = ST_PREAMBLE;  cfg_s = 1'b1;
                end else if (byte_s) begin
                    state_s = ST_DROP;  reason_s = RSN_PREAMBLE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (rxDataLastIn) begin
                    state_s = ST_IDLE;  drop_s = 1'b1;  drop_code_s = RSN_PREAMBLE;
                end else if (byte_s && (rxDataIn == SFD_BYTE)) begin
                    state_s = ST_HEADER;  sfd_s = 1'b1;
                end else if (byte_s && ((rxDataIn != PREAMBLE_BYTE) || (pre_cnt_r == 3'(PREAMBLE_MAX)))) begin
                    state_s = ST_DROP;  reason_s = RSN_PREAMBLE;
                end else begin
                    state_s = ST_PREAMBLE;
                end
            end
            ST_HEADER: begin
                if (rxDataLastIn) begin
                    state_s = ST_IDLE;  drop_s = 1'b1;  drop_code_s = RSN_RUNT;
                end else if (byte_s && too_long_s) begin
                    state_s = ST_DROP;  reason_s = RSN_LONG;
                end else if (byte_s && (hdr_idx_r == 4'd5) && !addr_ok_s) begin
                    state_s = ST_DROP;  reason_s = RSN_ADDR;
                end else if (byte_s && (hdr_idx_r == 4'(HDR_LEN - 1))) begin
                    state_s = ST_PAYLOAD;  to_payload_s = 1'b1;
                end else begin
                    state_s = ST_HEADER;
                end
            end
            ST_PAYLOAD: begin
                if (rxDataLastIn && min_ok_s) begin
                    state_s = ST_IDLE;  emit_last_s = 1'b1;  good_s = 1'b1;
                end else if (rxDataLastIn) begin
                    state_s = ST_IDLE;  flush_s = 1'b1;
                    drop_s = 1'b1;  drop_code_s = RSN_RUNT;
                end else if (byte_s && too_long_s) begin
                    state_s = ST_DROP;  reason_s = RSN_LONG;  flush_s = 1'b1;
                end else begin
                    push_s = byte_s;
                end
            end
            ST_DROP: begin
                if (rxDataLastIn) begin
                    state_s = ST_IDLE;  drop_s = 1'b1;  drop_code_s = reason_r;
                end else begin
                    state_s = ST_DROP;
                end
            end
            ST_DROP_SILENT: begin
                if (rxDataLastIn) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DROP_SILENT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, frame counters and configuration latched at preamble start.
    always_ff @(posedge rxClkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            state_r <= ST_IDLE;  reason_r <= RSN_NONE;  cnt_r <= {CNT_W{1'b0}};
            pre_cnt_r <= 3'd0;  hdr_idx_r <= 4'd0;  mac_r <= 48'h0;
            promisc_r <= 1'b0;  first_pend_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            reason_r <= reason_s;
            if ((state_r == ST_IDLE) || sfd_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (byte_s && (cnt_r != {CNT_W{1'b1}})) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            pre_cnt_r <= (state_r == ST_IDLE) ? 3'd1 : (byte_s ? pre_cnt_r + 3'd1 : pre_cnt_r);
            if (sfd_s) begin
                hdr_idx_r <= 4'd0;
            end else if ((state_r == ST_HEADER) && byte_s) begin
                hdr_idx_r <= hdr_idx_r + 4'd1;
            end
            if (cfg_s) begin
                mac_r     <= macAddrIn;
                promisc_r <= promiscIn;
            end
            if (to_payload_s) begin
                first_pend_r <= 1'b1;
            end else if (strip_valid_s || (state_r != ST_PAYLOAD)) begin
                first_pend_r <= 1'b0;
            end
        end
    end

    // Header field capture; source MAC and EtherType hold until the next header.
    always_ff @(posedge rxClkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            dst_r <= 40'h0;  src_mac_r <= 48'h0;  ether_type_r <= 16'h0;
        end else if ((state_r == ST_HEADER) && byte_s) begin
            if (hdr_idx_r < 4'd5) begin
                dst_r <= {dst_r[31:0], rxDataIn};
            end else if ((hdr_idx_r >= 4'd6) && (hdr_idx_r <= 4'd11)) begin
                src_mac_r <= {src_mac_r[39:0], rxDataIn};
            end else if (hdr_idx_r >= 4'd12) begin
                ether_type_r <= {ether_type_r[7:0], rxDataIn};
            end
        end
    end

    // Registered payload stream and status pulses.
    always_ff @(posedge rxClkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            pay_data_r <= 8'h00;  pay_valid_r <= 1'b0;  pay_first_r <= 1'b0;
            pay_last_r <= 1'b0;  good_r <= 1'b0;  drop_r <= 1'b0;
            reason_out_r <= 3'd0;  len_out_r <= {CNT_W{1'b0}};
        end else begin
            pay_data_r   <= strip_valid_s ? strip_data_s : 8'h00;
            pay_valid_r  <= strip_valid_s;
            pay_first_r  <= strip_valid_s && first_pend_r;
            pay_last_r   <= emit_last_s && (strip_fill_s != {FILL_W{1'b0}});
            good_r       <= good_s;
            drop_r       <= drop_s;
            reason_out_r <= drop_s ? drop_code_s : 3'd0;
            if (good_s || drop_s) begin
                len_out_r <= cnt_r;
            end
        end
    end

    assign payloadDataOut  = pay_data_r;
    assign payloadValidOut = pay_valid_r;
    assign payloadFirstOut = pay_first_r;
    assign payloadLastOut  = pay_last_r;
    assign srcMacOut       = src_mac_r;
    assign etherTypeOut    = ether_type_r;
    assign frameGoodOut    = good_r;
    assign frameDropOut    = drop_r;
    assign dropReasonOut   = reason_out_r;
    assign frameLenOut     = len_out_r;

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Scoreboard bench for eth_rx_frame_ctrl: frames are queued with their expected
// status and payload, and a negedge monitor checks what the DUT produces.
module tb_eth_rx_frame_ctrl;

    localparam logic [47:0] STA   = 48'h02_00_00_00_00_42;
    localparam logic [47:0] SRC   = 48'h02_11_22_33_44_55;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_99;
    localparam logic [47:0] BC    = 48'hFF_FF_FF_FF_FF_FF;

    logic        clk = 1'b0;
    logic        rstNIn, enIn, promiscIn, rxDataValidIn, rxDataLastIn;
    logic [47:0] macAddrIn;
    logic [7:0]  rxDataIn;
    logic [7:0]  payloadDataOut;
    logic        payloadValidOut, payloadFirstOut, payloadLastOut;
    logic [47:0] srcMacOut;
    logic [15:0] etherTypeOut;
    logic        frameGoodOut, frameDropOut;
    logic [2:0]  dropReasonOut;
    logic [10:0] frameLenOut;

    eth_rx_frame_ctrl dut (
        .rxClkIn(clk), .rstNIn(rstNIn), .enIn(enIn), .promiscIn(promiscIn),
        .macAddrIn(macAddrIn), .rxDataIn(rxDataIn), .rxDataValidIn(rxDataValidIn),
        .rxDataLastIn(rxDataLastIn), .payloadDataOut(payloadDataOut),
        .payloadValidOut(payloadValidOut), .payloadFirstOut(payloadFirstOut),
        .payloadLastOut(payloadLastOut), .srcMacOut(srcMacOut),
        .etherTypeOut(etherTypeOut), .frameGoodOut(frameGoodOut),
        .frameDropOut(frameDropOut), .dropReasonOut(dropReasonOut),
        .frameLenOut(frameLenOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit good;
        int reason;
        int len;
        int npay;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] pay_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] cur_q[$];
    int  total = 0, bad = 0;
    int  first_cnt = 0, first_pos = -1, last_pos = -1;
    bit  saw_last = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic any_out();
        return |{payloadDataOut, payloadValidOut, payloadFirstOut, payloadLastOut, srcMacOut,
                 etherTypeOut, frameGoodOut, frameDropOut, dropReasonOut, frameLenOut};
    endfunction

    task automatic add_pre(input int n);
        for (int i = 0; i < n; i++) tx_q.push_back(8'h55);
    endtask

    task automatic add_hdr(input logic [47:0] dst);
        tx_q.push_back(8'hD5);
        for (int i = 0; i < 6; i++) tx_q.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) tx_q.push_back(SRC[47-8*i -: 8]);
        tx_q.push_back(8'h08);
        tx_q.push_back(8'h00);
    endtask

    task automatic add_pay(input int n, input logic [7:0] base, input bit expect_it);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = base + 8'(i);
            tx_q.push_back(b);
            if (expect_it) pay_q.push_back(b);
        end
    endtask

    task automatic add_fcs();
        for (int i = 0; i < 4; i++) tx_q.push_back(8'hA0 + 8'(i));
    endtask

    task automatic expect_status(input bit good, input int reason, input int len, input int npay);
        exp_t e;
        e.good = good;  e.reason = reason;  e.len = len;  e.npay = npay;
        exp_q.push_back(e);
    endtask

    // Drives tx_q one byte per cycle, then the last strobe; optional mid-frame reset.
    task automatic send(input int rst_at);
        for (int i = 0; i < tx_q.size(); i++) begin
            @(posedge clk); #1;
            rxDataLastIn = 1'b0;  rxDataValidIn = 1'b1;  rxDataIn = tx_q[i];
            if (rst_at >= 0 && i == rst_at) rstNIn = 1'b0;
            if (rst_at >= 0 && i == rst_at + 3) rstNIn = 1'b1;
            if (rst_at >= 0 && i >= rst_at && i < rst_at + 3) begin
                #3;
                chk("reset_mid_outputs_zero", 64'(any_out()), 64'd0);
            end
        end
        @(posedge clk); #1;
        rxDataValidIn = 1'b0;  rxDataIn = 8'h00;  rxDataLastIn = 1'b1;
        tx_q.delete();
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        rxDataValidIn = 1'b0;  rxDataLastIn = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic check_status();
        exp_t       e;
        logic [8:0] gotb;
        logic [7:0] expb;
        if (exp_q.size() == 0) begin
            chk("spurious_status", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk("status_kind", 64'({frameGoodOut, frameDropOut}), e.good ? 64'd2 : 64'd1);
            if (e.len >= 0) chk("frame_len", 64'(frameLenOut), 64'(e.len));
            if (e.good) begin
                chk("pay_count", 64'(cur_q.size()), 64'(e.npay));
                chk("first_pos", 64'(first_pos), 64'd0);
                chk("first_cnt", 64'(first_cnt), 64'd1);
                chk("last_pos", 64'(last_pos), 64'(e.npay - 1));
                chk("src_mac", 64'(srcMacOut), 64'(SRC));
                chk("ether_type", 64'(etherTypeOut), 64'h0800);
                for (int i = 0; i < e.npay; i++) begin
                    expb = (pay_q.size() != 0) ? pay_q.pop_front() : 8'h00;
                    gotb = (i < cur_q.size()) ? {1'b0, cur_q[i]} : 9'h100;
                    chk("pay_byte", 64'(gotb), 64'(expb));
                end
            end else begin
                chk("drop_reason", 64'(dropReasonOut), 64'(e.reason));
                chk("no_last_on_drop", 64'(saw_last), 64'd0);
                if (e.npay >= 0) chk("drop_pay_count", 64'(cur_q.size()), 64'(e.npay));
            end
        end
    endtask

    // Collects payload per frame and checks it when a status pulse arrives.
    always @(negedge clk) begin
        if (!rstNIn) begin
            cur_q.delete();  saw_last = 1'b0;  first_cnt = 0;  first_pos = -1;  last_pos = -1;
        end else begin
            if (payloadValidOut) begin
                if (payloadFirstOut) begin first_cnt++; first_pos = cur_q.size(); end
                if (payloadLastOut) begin saw_last = 1'b1; last_pos = cur_q.size(); end
                cur_q.push_back(payloadDataOut);
            end
            if (frameGoodOut || frameDropOut) begin
                check_status();
                cur_q.delete();  saw_last = 1'b0;  first_cnt = 0;  first_pos = -1;  last_pos = -1;
            end
        end
    end

    initial begin
        rstNIn = 1'b0;  enIn = 1'b1;  promiscIn = 1'b0;  macAddrIn = STA;
        rxDataIn = 8'h00;  rxDataValidIn = 1'b0;  rxDataLastIn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_zero", 64'(any_out()), 64'd0);
        @(posedge clk); #1;
        rstNIn = 1'b1;
        idle(2);

        // Minimum-size good frame to our station.
        add_pre(7); add_hdr(STA); add_pay(46, 8'h00, 1'b1); add_fcs();
        expect_status(1'b1, 0, 64, 46); send(-1);
        // One byte short: runt.
        add_pre(7); add_hdr(STA); add_pay(45, 8'h00, 1'b0); add_fcs();
        expect_status(1'b0, 3, 63, -1); send(-1);
        // Foreign destination, filter on.
        add_pre(7); add_hdr(OTHER); add_pay(46, 8'h00, 1'b0); add_fcs();
        expect_status(1'b0, 2, 64, 0); send(-1);
        promiscIn = 1'b1;
        add_pre(7); add_hdr(OTHER); add_pay(46, 8'h40, 1'b1); add_fcs();
        expect_status(1'b1, 0, 64, 46); send(-1);
        promiscIn = 1'b0;
        add_pre(7); add_hdr(BC); add_pay(50, 8'hC0, 1'b1); add_fcs();
        expect_status(1'b1, 0, 68, 50); send(-1);
        // Broken preamble, then an over-long preamble.
        add_pre(1); tx_q.push_back(8'h54); add_pay(20, 8'h00, 1'b0);
        expect_status(1'b0, 1, -1, 0); send(-1);
        add_pre(9); add_hdr(STA); add_pay(46, 8'h00, 1'b0); add_fcs();
        expect_status(1'b0, 1, -1, 0); send(-1);
        // Frame ends inside the header.
        add_pre(7); tx_q.push_back(8'hD5);
        for (int i = 0; i < 5; i++) tx_q.push_back(STA[47-8*i -: 8]);
        expect_status(1'b0, 3, 5, 0); send(-1);
        // Oversized frame.
        add_pre(7); add_hdr(STA); add_pay(1582, 8'h00, 1'b0); add_fcs();
        expect_status(1'b0, 4, 1600, -1); send(-1);
        // Receiver disabled: no status at all.
        enIn = 1'b0;
        add_pre(7); add_hdr(STA); add_pay(46, 8'h00, 1'b0); add_fcs();
        send(-1);
        enIn = 1'b1;
        add_pre(7); add_hdr(STA); add_pay(100, 8'h80, 1'b1); add_fcs();
        expect_status(1'b1, 0, 118, 100); send(-1);
        // Reset mid-payload; remainder lands in IDLE as garbage.
        add_pre(7); add_hdr(STA); add_pay(46, 8'h10, 1'b0); add_fcs();
        expect_status(1'b0, 1, -1, 0); send(42);
        add_pre(7); add_hdr(STA); add_pay(46, 8'h20, 1'b1); add_fcs();
        expect_status(1'b1, 0, 64, 46); send(-1);
        idle(2);

        for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(posedge clk);
        chk("drain_status", 64'(exp_q.size()), 64'd0);
        chk("drain_payload", 64'(pay_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
